// File: rtl/vcm_i2c_responder.sv
// I2C slave standing in for the VCM focus driver: accepts 16-bit VCM words at DEV_ADDR.
// Optional macro VCM_READBACK_EN: when defined, reads return the latched word; otherwise reads are not acknowledged.

module vcm_i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h0C,
    parameter int         FILT_LEN = 3,
    parameter int         HOLD_CYC = 4
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    output logic [15:0] VCM_DATA,
    output logic [9:0]  STEP,
    output logic        DATA_VALID,
    output logic        BUSY
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_filt;
    logic [1:0]    r_filt_d;
    logic [FW-1:0] r_fcnt [2];

    state_t        r_state;
    logic [6:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_byte_cnt;
    logic [15:0]   r_shadow;
    logic          r_hold_act;
    logic [HW-1:0] r_hold_cnt;
`ifdef VCM_READBACK_EN
    logic          r_rd_idx;
    logic [7:0]    w_rd_byte;
`endif

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;
    logic       w_byte_done;
    logic       w_addr_ack;
    logic       w_oe_want;

    // NOTE: synchroniser and filter reset to the idle-high bus level so that
    // leaving reset can never look like a START or STOP.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            r_sync1  <= {SDA_IN, SCL_IN};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == FW'(FILT_LEN - 1)) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + FW'(1);
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    assign w_scl       = r_filt[0];
    assign w_sda       = r_filt[1];
    assign w_scl_rise  = w_scl & ~r_filt_d[0];
    assign w_scl_fall  = ~w_scl & r_filt_d[0];
    assign w_start     = w_scl & r_filt_d[0] & r_filt_d[1] & ~w_sda;
    assign w_stop      = w_scl & r_filt_d[0] & ~r_filt_d[1] & w_sda;
    assign w_byte      = {r_shift, w_sda};
    assign w_byte_done = w_scl_rise & (r_bit_cnt == 3'd7);

`ifdef VCM_READBACK_EN
    assign w_addr_ack = (w_byte[7:1] == DEV_ADDR);
    assign w_rd_byte  = r_rd_idx ? VCM_DATA[7:0] : VCM_DATA[15:8];
`else
    assign w_addr_ack = (w_byte[7:1] == DEV_ADDR) & ~w_byte[0];
`endif

    // Level SDA_OE should take once the post-fall hold time has elapsed.
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        w_oe_want = 1'b0;
        case (r_state)
            ST_ADDR_ACK,
            ST_WR_ACK:   w_oe_want = 1'b1;
`ifdef VCM_READBACK_EN
            ST_RD_BYTE:  w_oe_want = ~w_rd_byte[3'd7 - r_bit_cnt];
`endif
            default:     w_oe_want = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shadow   <= '0;
            r_hold_act <= 1'b0;
            r_hold_cnt <= '0;
            SDA_OE     <= 1'b0;
            VCM_DATA   <= '0;
            STEP       <= '0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
`ifdef VCM_READBACK_EN
            r_rd_idx   <= 1'b0;
`endif
        end else begin
            DATA_VALID <= 1'b0;

            if (w_scl_fall) begin
                r_hold_act <= 1'b1;
                r_hold_cnt <= HW'(HOLD_CYC - 1);
            end else if (r_hold_act) begin
                if (r_hold_cnt == '0) begin
                    r_hold_act <= 1'b0;
                    SDA_OE     <= w_oe_want;
                end else begin
                    r_hold_cnt <= r_hold_cnt - HW'(1);
                end
            end

            // Bus conditions take priority over bit sampling in the same cycle.
            if (w_stop) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= '0;
                r_hold_act <= 1'b0;
                SDA_OE     <= 1'b0;
                BUSY       <= 1'b0;
            end else if (w_start) begin
                r_state    <= ST_ADDR;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_hold_act <= 1'b0;
                SDA_OE     <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ST_ADDR: begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            if (w_addr_ack) begin
                                r_state <= ST_ADDR_ACK;
                                BUSY    <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                                BUSY    <= 1'b0;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
`ifdef VCM_READBACK_EN
                        if (r_shift[0]) begin
                            r_state  <= ST_RD_BYTE;
                            r_rd_idx <= 1'b0;
                        end else begin
                            r_state    <= ST_WR_BYTE;
                            r_byte_cnt <= '0;
                        end
`else
                        r_state    <= ST_WR_BYTE;
                        r_byte_cnt <= '0;
`endif
                    end

                    ST_WR_BYTE: begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            if (r_byte_cnt == 2'd0) begin
                                r_shadow[15:8] <= w_byte;
                                r_state        <= ST_WR_ACK;
                            end else if (r_byte_cnt == 2'd1) begin
                                r_shadow[7:0]  <= w_byte;
                                r_state        <= ST_WR_ACK;
                            end else begin
                                r_state <= ST_IGNORE;
                                BUSY    <= 1'b0;
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        // The second data byte commits on the rise of its ACK clock.
                        if (r_byte_cnt == 2'd1) begin
                            VCM_DATA   <= r_shadow;
                            STEP       <= r_shadow[13:4];
                            DATA_VALID <= 1'b1;
                        end
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_state    <= ST_WR_BYTE;
                    end

`ifdef VCM_READBACK_EN
                    ST_RD_BYTE: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_RD_ACK;
                        end
                    end

                    ST_RD_ACK: begin
                        if (!w_sda) begin
                            r_rd_idx <= ~r_rd_idx;
                            r_state  <= ST_RD_BYTE;
                        end else begin
                            r_state <= ST_IGNORE;
                            BUSY    <= 1'b0;
                        end
                    end
`endif

                    ST_IDLE,
                    ST_IGNORE: r_state <= r_state;

                    default: begin
                        r_state <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vcm_i2c_responder.sv
// Bench for vcm_i2c_responder: bit-level I2C master plus a transaction-level model of the VCM word.
// Read expectations follow VCM_READBACK_EN exactly as the design does.

module tb_vcm_i2c_responder;

    localparam int Q = 25;  // quarter of an I2C bit period, in clocks
`ifdef VCM_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] vcm;
    logic [9:0]  step;
    logic        dv;
    logic        busy;

    always #10 clk = ~clk;

    // Open-drain bus: either side may pull SDA low.
    assign sda_line = sda_m & ~sda_oe;

    vcm_i2c_responder dut (
        .CLK_50     (clk),
        .RESET_N    (rst_n),
        .SCL_IN     (scl_m),
        .SDA_IN     (sda_line),
        .SDA_OE     (sda_oe),
        .VCM_DATA   (vcm),
        .STEP       (step),
        .DATA_VALID (dv),
        .BUSY       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, updated at transaction granularity.
    logic [15:0] m_vcm    = 16'h0000;
    logic [7:0]  m_hi     = 8'h00;
    int          m_pulses = 0;
    int          m_nbytes = 0;
    bit          m_wr_ok  = 1'b0;
    bit          m_rd_idx = 1'b0;
    bit          m_stable = 1'b0;
    bit          m_quiet  = 1'b0;
    int          dv_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic dv_prev  = 1'b0;
    logic scl_prev = 1'b1;
    logic oe_prev  = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_stable) begin
                check("vcm_data", vcm, m_vcm);
                check("step", step, m_vcm[13:4]);
                check("dv_idle", dv, 1'b0);
            end
            if (dv) begin
                dv_seen++;
                check("dv_width", dv_prev, 1'b0);
            end
            if (m_quiet) check("oe_quiet", sda_oe, 1'b0);
            if (scl_m && scl_prev) check("oe_scl_high", sda_oe, oe_prev);
        end
        dv_prev  = dv;
        scl_prev = scl_m;
        oe_prev  = sda_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
        m_wr_ok  = 1'b0;
        m_nbytes = 0;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(2 * Q);
        check("busy_after_stop", busy, 1'b0);
        check("oe_after_stop", sda_oe, 1'b0);
        check("dv_count", dv_seen, m_pulses);
        m_quiet = 1'b0;
    endtask

    task automatic write_bit(input bit b, input bit glitch);
        sda_m = b;
        if (glitch) begin
            cyc(10);
            scl_m = 1'b1; cyc(2);
            scl_m = 1'b0; cyc(Q - 12);
        end else begin
            cyc(Q);
        end
        scl_m = 1'b1; cyc(2 * Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic read_bit(output bit b);
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        b = sda_line; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic send_addr(input logic [7:0] a);
        bit b;
        bit exp_ack;
        exp_ack = (a[7:1] == 7'h0C) && (!a[0] || READBACK);
        for (int i = 7; i >= 0; i--) write_bit(a[i], 1'b0);
        read_bit(b);
        check("addr_ack", !b, exp_ack);
        if (exp_ack) check("busy_addressed", busy, 1'b1);
        else         check("busy_unaddressed", busy, 1'b0);
        m_wr_ok  = exp_ack && !a[0];
        m_nbytes = 0;
        m_rd_idx = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d, input int glitch_bit);
        bit b;
        bit exp_ack;
        bit commit;
        exp_ack = m_wr_ok && (m_nbytes < 2);
        commit  = exp_ack && (m_nbytes == 1);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
        if (commit) m_stable = 1'b0;
        read_bit(b);
        check("data_ack", !b, exp_ack);
        if (exp_ack && m_nbytes == 0) m_hi = d;
        if (commit) begin
            m_vcm = {m_hi, d};
            m_pulses++;
        end
        if (!exp_ack) m_wr_ok = 1'b0;
        m_stable = 1'b1;
        m_nbytes++;
    endtask

    task automatic recv_data(input bit master_ack);
        bit b;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        check("rd_byte", d, m_rd_idx ? m_vcm[7:0] : m_vcm[15:8]);
        write_bit(!master_ack, 1'b0);
        if (master_ack) m_rd_idx = ~m_rd_idx;
    endtask

    initial begin
        int dv0;
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(5);
        check("rst_vcm", vcm, 16'h0000);
        check("rst_step", step, 10'h000);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dv", dv, 1'b0);
        rst_n = 1'b1;
        cyc(20);
        m_stable = 1'b1;

        // Plain two-byte write.
        bus_start();
        send_addr(8'h18);
        send_data(8'h3A, -1);
        send_data(8'h50, -1);
        bus_stop();
        check("lit_vcm_3a50", vcm, 16'h3A50);
        check("lit_step_3a5", step, 10'h3A5);
        check("lit_dv_1", dv_seen, 1);

        // Read-back of the latched word (not acknowledged without the read option).
        bus_start();
        send_addr(8'h19);
        if (READBACK) begin
            recv_data(1'b1);
            recv_data(1'b1);
            recv_data(1'b0);
        end
        bus_stop();

        // Wrong address: the slave must stay silent.
        m_quiet = 1'b1;
        bus_start();
        send_addr(8'h1A);
        send_data(8'h12, -1);
        send_data(8'h34, -1);
        bus_stop();
        check("lit_vcm_unchanged", vcm, 16'h3A50);

        // Repeated START discards the partial write.
        dv0 = dv_seen;
        bus_start();
        send_addr(8'h18);
        send_data(8'h12, -1);
        bus_start();
        send_addr(8'h18);
        send_data(8'h00, -1);
        send_data(8'h40, -1);
        bus_stop();
        check("lit_vcm_0040", vcm, 16'h0040);
        check("lit_dv_rs", dv_seen - dv0, 1);

        // Third data byte is refused.
        bus_start();
        send_addr(8'h18);
        send_data(8'hAA, -1);
        send_data(8'hBB, -1);
        send_data(8'hCC, -1);
        bus_stop();
        check("lit_vcm_aabb", vcm, 16'hAABB);

        // SCL glitch inside a data byte must not add a bit.
        bus_start();
        send_addr(8'h18);
        send_data(8'h5A, 3);
        send_data(8'hC3, -1);
        bus_stop();
        check("lit_vcm_5ac3", vcm, 16'h5AC3);

        // Reset in the middle of a write.
        bus_start();
        send_addr(8'h18);
        send_data(8'h77, -1);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        write_bit(1'b0, 1'b0);
        m_stable = 1'b0;
        rst_n = 1'b0;
        cyc(3);
        check("midrst_vcm", vcm, 16'h0000);
        check("midrst_oe", sda_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_step", step, 10'h000);
        m_vcm = 16'h0000;
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(20);
        rst_n = 1'b1;
        cyc(20);
        m_stable = 1'b1;

        // Recovery after reset.
        bus_start();
        send_addr(8'h18);
        send_data(8'h12, -1);
        send_data(8'h34, -1);
        bus_stop();
        check("lit_vcm_1234", vcm, 16'h1234);
        check("lit_step_123", step, 10'h123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
